// File: rtl/alu_result_fifo.sv
// Capture FIFO for 4-bit ALU results with sticky overflow and a saturating carry counter.
// Optional macro PARITY_CHECK_EN adds a sticky perr output for stored-parity mismatches.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [3:0]               in_result,
  input  logic                     in_carry,
  input  logic                     in_parity,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [5:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CW-1:0]            carry_cnt
`ifdef PARITY_CHECK_EN
  ,
  output logic                     perr
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [5:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_overflow;
  logic [CW-1:0]   r_carry_cnt;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [5:0]      w_entry;

  // clr and ena gate every state change, so push/pop are only live in normal operation
  assign w_full  = (r_count == CNTW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ena & ~clr & ~w_empty & out_ready;
  assign w_push  = ena & ~clr & in_valid & (~w_full | w_pop);
  assign w_drop  = ena & ~clr & in_valid & w_full & ~w_pop;
  assign w_entry = {in_parity, in_carry, in_result};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_carry_cnt <= '0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_carry_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
      if (w_drop) r_overflow <= 1'b1;
      if (w_push && in_carry && (r_carry_cnt != {CW{1'b1}}))
        r_carry_cnt <= r_carry_cnt + CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible while counted as occupied
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

`ifdef PARITY_CHECK_EN
  logic r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (clr) begin
      r_perr <= 1'b0;
    end else if (w_push && ((^in_result) != in_parity)) begin
      r_perr <= 1'b1;
    end
  end

  assign perr = r_perr;
`endif

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? 6'b0 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign carry_cnt = r_carry_cnt;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: queue-based reference model, negedge monitor,
// two instances (CW=8 and CW=2) driven in lockstep.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_result = 4'd0;
  logic       in_carry = 1'b0;
  logic       in_parity = 1'b0;
  logic       out_ready = 1'b0;

  logic       out_valid, full, empty, overflow;
  logic [5:0] out_data;
  logic [2:0] count;
  logic [7:0] carry_cnt;
  logic       out_valid2, full2, empty2, overflow2;
  logic [5:0] out_data2;
  logic [2:0] count2;
  logic [1:0] carry_cnt2;
`ifdef PARITY_CHECK_EN
  logic       perr, perr2;
`endif

  alu_result_fifo #(.DEPTH(DEPTH), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .in_result(in_result), .in_carry(in_carry), .in_parity(in_parity),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .carry_cnt(carry_cnt)
`ifdef PARITY_CHECK_EN
    , .perr(perr)
`endif
  );

  alu_result_fifo #(.DEPTH(DEPTH), .CW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .in_valid(in_valid),
    .in_result(in_result), .in_carry(in_carry), .in_parity(in_parity),
    .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2),
    .count(count2), .full(full2), .empty(empty2), .overflow(overflow2),
    .carry_cnt(carry_cnt2)
`ifdef PARITY_CHECK_EN
    , .perr(perr2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [5:0] mq[$];
  bit         m_ovf;
  int         m_cc;
  int         m_cc2;
  bit         m_perr;
  bit         mon_en = 1'b0;
  bit         mp_pop, mp_push, mp_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_cc   = 0;
    m_cc2  = 0;
    m_perr = 1'b0;
  endfunction

  function automatic bit par(input logic [3:0] r);
    return ^r;
  endfunction

  // Reference model: FIFO as a queue, updated from the inputs present at each rising edge
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n || clr) begin
        m_reset();
      end else if (ena) begin
        mp_full = (mq.size() == DEPTH);
        mp_pop  = (mq.size() > 0) && out_ready;
        mp_push = in_valid && (!mp_full || mp_pop);
        if (in_valid && mp_full && !mp_pop) m_ovf = 1'b1;
        if (mp_pop) void'(mq.pop_front());
        if (mp_push) begin
          mq.push_back({in_parity, in_carry, in_result});
          if (in_carry) begin
            if (m_cc < 255) m_cc++;
            if (m_cc2 < 3) m_cc2++;
          end
          if ((^in_result) != in_parity) m_perr = 1'b1;
        end
      end
    end
  end

  // Monitor: compares every observable output against the model away from the active edge
  initial begin
    logic [5:0] exp_data;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        exp_data = (mq.size() > 0) ? mq[0] : 6'b0;
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out_data", 32'(out_data), 32'(exp_data));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("carry_cnt", 32'(carry_cnt), 32'(m_cc));
        chk("out_data_cw2", 32'(out_data2), 32'(exp_data));
        chk("carry_cnt_cw2", 32'(carry_cnt2), 32'(m_cc2));
`ifdef PARITY_CHECK_EN
        chk("perr", 32'(perr), 32'(m_perr));
`endif
      end
    end
  end

  task automatic step(input bit v, input logic [3:0] r, input bit c, input bit p,
                      input bit rdy, input bit e = 1'b1, input bit cl = 1'b0);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_result = r;
    in_carry  = c;
    in_parity = p;
    out_ready = rdy;
    ena       = e;
    clr       = cl;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clr();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    bit         c, p;
    repeat (3) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    ena    = 1'b1;
    mon_en = 1'b1;
    idle();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_data", 32'(out_data), 32'd0);

    // Fill to full without draining
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, par(4'(i)), 1'b0);
    idle();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_head", 32'(out_data), 32'h21);
    chk("fill_ovf", 32'(overflow), 32'd0);

    // Drop while full, then drain
    step(1'b1, 4'd5, 1'b0, par(4'd5), 1'b0);
    idle();
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd4);
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_data", 32'(out_data), 32'd0);

    // Push and pop together while full
    do_clr();
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, par(4'(i)), 1'b0);
    step(1'b1, 4'd9, 1'b0, par(4'd9), 1'b1);
    idle();
    chk("pp_full_count", 32'(count), 32'd4);
    chk("pp_full_ovf", 32'(overflow), 32'd0);
    chk("pp_full_head", 32'(out_data), 32'h22);
    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Carry counter saturation in the CW=2 instance
    do_clr();
    for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 1'b1, par(4'(i)), 1'b1);
    idle();
    chk("carry_cw2_sat", 32'(carry_cnt2), 32'd3);
    step(1'b1, 4'd4, 1'b1, par(4'd4), 1'b1);
    idle();
    chk("carry_cw2_hold", 32'(carry_cnt2), 32'd3);
    chk("carry_cw8", 32'(carry_cnt), 32'd4);

    // ena=0 holds everything, then clr wins over a push
    do_clr();
    step(1'b1, 4'd1, 1'b0, par(4'd1), 1'b0);
    step(1'b1, 4'd2, 1'b0, par(4'd2), 1'b0);
    repeat (3) step(1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("ena0_count", 32'(count), 32'd2);
    chk("ena0_head", 32'(out_data), 32'h21);
    chk("ena0_carry", 32'(carry_cnt), 32'd0);
    step(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_carry", 32'(carry_cnt), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Bad parity is still stored
    step(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    idle();
    chk("parity_entry", 32'(out_data), 32'h07);
`ifdef PARITY_CHECK_EN
    chk("parity_perr", 32'(perr), 32'd1);
`endif

    // Saturate the 8-bit carry counter
    do_clr();
    repeat (260) step(1'b1, 4'($urandom), 1'b1, 1'($urandom), 1'b1);
    idle();
    chk("carry_cw8_sat", 32'(carry_cnt), 32'd255);

    // Randomized traffic with an asynchronous reset in the middle
    do_clr();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      r = 4'($urandom);
      c = 1'($urandom);
      p = ($urandom_range(0, 7) == 0) ? ~par(r) : par(r);
      step(1'($urandom), r, c, p, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
